// File: rtl/vec_sub_seq_if.sv
// Handshake bundle for vec_sub_seq.
// Carries the input pair, the result vector and the busy flag.
interface vec_sub_seq_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH*SIZE-1:0] a;
  logic [WIDTH*SIZE-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH*SIZE-1:0] y;
  logic                  busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/vec_sub_seq.sv
// Lane-serial IEEE-754 vector subtractor: y = a - b, one lane per cycle
// through a single shared Add core (round to nearest even).
module Add #(
  parameter int EW = 8,
  parameter int MW = 23
) (
  input  logic [EW+MW:0] a,
  input  logic [EW+MW:0] b,
  output logic [EW+MW:0] y
);
  localparam int W = EW + MW + 1;
  localparam int F = MW + 1;
  localparam int X = F + 3;

  logic           a_nan, b_nan, a_inf, b_inf;
  logic           swap, sub, sx, sy, stk, up;
  logic [W-1:0]   x, yy;
  logic [EW+1:0]  ex, ey, d, e;
  logic [X-1:0]   xm, ym, ys, msk;
  logic [X:0]     s;
  logic [F:0]     r;

  always_comb begin
    a_nan = (&a[W-2:MW]) && (|a[MW-1:0]);
    b_nan = (&b[W-2:MW]) && (|b[MW-1:0]);
    a_inf = (&a[W-2:MW]) && !(|a[MW-1:0]);
    b_inf = (&b[W-2:MW]) && !(|b[MW-1:0]);
    swap  = b[W-2:0] > a[W-2:0];
    x     = swap ? b : a;
    yy    = swap ? a : b;
    sx    = x[W-1];
    sy    = yy[W-1];
    sub   = sx ^ sy;
    ex    = (x[W-2:MW] == '0) ? (EW+2)'(1) : {2'b00, x[W-2:MW]};
    ey    = (yy[W-2:MW] == '0) ? (EW+2)'(1) : {2'b00, yy[W-2:MW]};
    xm    = {|x[W-2:MW], x[MW-1:0], 3'b000};
    ym    = {|yy[W-2:MW], yy[MW-1:0], 3'b000};
    d     = ex - ey;
    // shift >= X zeroes both terms, leaving only sticky
    msk   = ~({X{1'b1}} << d);
    stk   = |(ym & msk);
    ys    = (ym >> d) | {{(X-1){1'b0}}, stk};
    s     = sub ? ({1'b0, xm} - {1'b0, ys})
                : ({1'b0, xm} + {1'b0, ys});
    e     = ex;
    if (s[X]) begin
      s = {1'b0, s[X:2], s[1] | s[0]};
      e = e + (EW+2)'(1);
    end else begin
      for (int i = 0; i < X; i++) begin
        if (!s[X-1] && e > (EW+2)'(1)) begin
          s = s << 1;
          e = e - (EW+2)'(1);
        end
      end
    end
    up = s[2] & ((|s[1:0]) | s[3]);
    r  = {1'b0, s[X-1:3]} + (F+1)'(up);
    if (r[F]) begin
      r = {1'b0, r[F:1]};
      e = e + (EW+2)'(1);
    end
    y = {sx, (r[F-1] ? e[EW-1:0] : {EW{1'b0}}), r[MW-1:0]};
    if (r[F-1] && e >= {2'b00, {EW{1'b1}}})
      y = {sx, {EW{1'b1}}, {MW{1'b0}}};
    if (r == '0)
      y = {sx & sy, {(W-1){1'b0}}};
    if (a_inf || b_inf) begin
      if (a_inf && b_inf && (a[W-1] ^ b[W-1]))
        y = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};
      else
        y = a_inf ? a : b;
    end
    if (a_nan)
      y = a | {{(EW+1){1'b0}}, 1'b1, {(MW-1){1'b0}}};
    else if (b_nan)
      y = b | {{(EW+1){1'b0}}, 1'b1, {(MW-1){1'b0}}};
  end
endmodule

module vec_sub_seq #(
  parameter int WIDTH     = 32,
  parameter int SIZE      = 4,
  parameter int LANE_BITS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  vec_sub_seq_if.slave bus
);
  localparam int EW = (WIDTH == 64) ? 11 : (WIDTH == 16) ? 5 : 8;
  localparam int MW = WIDTH - 1 - EW;
  localparam logic [LANE_BITS-1:0] LAST = LANE_BITS'(SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state, state_nx;
  logic [LANE_BITS-1:0]  lane;
  logic [WIDTH*SIZE-1:0] a_reg, b_reg, y_reg;
  logic [WIDTH-1:0]      a_ln, b_ln, b_neg, sum;

  assign a_ln  = a_reg[lane*WIDTH +: WIDTH];
  assign b_ln  = b_reg[lane*WIDTH +: WIDTH];
  assign b_neg = {~b_ln[WIDTH-1], b_ln[WIDTH-2:0]};

  Add #(.EW(EW), .MW(MW)) u_add (
    .a (a_ln),
    .b (b_neg),
    .y (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (bus.in_valid)  state_nx = RUN;
      RUN:  if (lane == LAST)  state_nx = DONE;
      DONE: if (bus.out_ready) state_nx = IDLE;
      default:                 state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= '0;
      a_reg <= '0;
      b_reg <= '0;
      y_reg <= '0;
    end else begin
      if (state == IDLE && bus.in_valid) begin
        a_reg <= bus.a;
        b_reg <= bus.b;
        lane  <= '0;
      end
      if (state == RUN) begin
        y_reg[lane*WIDTH +: WIDTH] <= sum;
        if (lane != LAST) lane <= lane + LANE_BITS'(1);
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.y         = y_reg;
endmodule

// File: tb/tb_vec_sub_seq.sv
// Directed bench for vec_sub_seq: latency, backpressure,
// streaming, input protocol and asynchronous reset.
module tb_vec_sub_seq;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;
  int   cyc;
  longint t_acc, t_prev;
  logic [127:0] va, vb, ve;

  vec_sub_seq_if #(.WIDTH(32), .SIZE(4)) bus ();

  vec_sub_seq #(.WIDTH(32), .SIZE(4), .LANE_BITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] int2f(input int v);
    logic [31:0] m;
    int p;
    if (v == 0) return 32'h0;
    m = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    return {v < 0, 8'(127 + p), 23'(m << (23 - p))};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [127:0] a_v, input logic [127:0] b_v);
    @(negedge clk);
    bus.a        = a_v;
    bus.b        = b_v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int c);
    c = 0;
    do begin
      @(posedge clk);
      c++;
      #1;
    end while (!bus.out_valid && c < 20);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_y", bus.y, 128'd0);

    // basic vector with backpressure
    accept({32'h40B00000, 32'h3F800000, 32'h3F800000, 32'h40400000},
           {32'h3F000000, 32'hBF800000, 32'h3F800000, 32'h3F800000});
    bus.in_valid = 1'b0;
    bus.a = '1;
    bus.b = '1;
    chk("basic_in_ready", 128'(bus.in_ready), 128'd0);
    chk("basic_busy", 128'(bus.busy), 128'd1);
    wait_out(cyc);
    chk("basic_latency", 128'(cyc), 128'd4);
    ve = {32'h40A00000, 32'h40000000, 32'h00000000, 32'h40000000};
    chk("basic_y", bus.y, ve);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
      chk("bp_y", bus.y, ve);
      chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_rel_out_valid", 128'(bus.out_valid), 128'd0);
    chk("bp_rel_in_ready", 128'(bus.in_ready), 128'd1);
    chk("bp_rel_busy", 128'(bus.busy), 128'd0);

    // back-to-back streaming, in_valid held high throughout
    t_prev = 0;
    for (int v = 0; v < 8; v++) begin
      for (int i = 0; i < 4; i++) begin
        int ai, bi;
        ai = int'($urandom_range(0, 2000)) - 1000;
        bi = int'($urandom_range(0, 2000)) - 1000;
        if (v == 0) bi = ai;
        if (v == 1 && i == 0) ai = 0;
        va[32*i +: 32] = int2f(ai);
        vb[32*i +: 32] = int2f(bi);
        ve[32*i +: 32] = int2f(ai - bi);
      end
      bus.a = va;
      bus.b = vb;
      bus.in_valid = 1'b1;
      @(posedge clk);
      t_acc = $time;
      if (v > 0) chk("stream_spacing", 128'((t_acc - t_prev) / 10), 128'd6);
      t_prev = t_acc;
      #1;
      if (v == 7) bus.in_valid = 1'b0;
      chk("stream_in_ready", 128'(bus.in_ready), 128'd0);
      wait_out(cyc);
      chk("stream_latency", 128'(cyc), 128'd4);
      chk("stream_y", bus.y, ve);
      @(posedge clk);
      #1;
      chk("stream_idle", 128'(bus.in_ready), 128'd1);
    end

    // a/b change and in_valid stays high during RUN
    va = {int2f(7), int2f(0), int2f(-2), int2f(10)};
    vb = {int2f(-7), int2f(0), int2f(3), int2f(4)};
    ve = {int2f(14), 32'h0, int2f(-5), int2f(6)};
    accept(va, vb);
    bus.a = {int2f(100), int2f(200), int2f(300), int2f(400)};
    bus.b = {int2f(1), int2f(2), int2f(3), int2f(4)};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("proto_in_ready", 128'(bus.in_ready), 128'd0);
    end
    wait_out(cyc);
    chk("proto_latency", 128'(cyc), 128'd1);
    chk("proto_y", bus.y, ve);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("proto_no_accept", 128'(bus.busy), 128'd0);

    // asynchronous reset at lane 2
    accept({int2f(9), int2f(8), int2f(7), int2f(6)},
           {int2f(1), int2f(1), int2f(1), int2f(1)});
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", 128'(bus.in_ready), 128'd1);
    chk("mrst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("mrst_busy", 128'(bus.busy), 128'd0);
    chk("mrst_y", bus.y, 128'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("mrst_hold_out_valid", 128'(bus.out_valid), 128'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mrst_rel_y", bus.y, 128'd0);
    chk("mrst_rel_out_valid", 128'(bus.out_valid), 128'd0);
    va = {int2f(-3), int2f(50), int2f(1), int2f(12)};
    vb = {int2f(-3), int2f(-50), int2f(4), int2f(5)};
    ve = {32'h0, int2f(100), int2f(-3), int2f(7)};
    accept(va, vb);
    bus.in_valid = 1'b0;
    wait_out(cyc);
    chk("mrst_fresh_latency", 128'(cyc), 128'd4);
    chk("mrst_fresh_y", bus.y, ve);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
